// File: rtl/board_link_pkg.sv
// board_link_pkg: shared packet constants, field offsets, receiver FSM states
// and the packet checksum used by board_link_rx.
package board_link_pkg;
   localparam int PKT_LEN = 208;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int SYNC_LSB = 0;
   localparam int BOARD_LSB = 8;
   localparam int BOARD_MSB = 169;
   localparam int MOVE_LSB = 170;
   localparam int MOVE_MSB = 177;
   localparam int TURN_BIT = 178;
   localparam int RSVD_LSB = 179;
   localparam int RSVD_MSB = 199;
   localparam int CHK_LSB = 200;
   localparam int CHK_MSB = 207;
   localparam int CHK_BYTES = CHK_LSB / 8;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLDOFF} state_t;

   function automatic logic [7:0] calc_chk(input logic [PKT_LEN-1:0] p);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < CHK_BYTES; i++) c ^= p[i*8 +: 8];
      return c;
   endfunction
endpackage

// File: rtl/oversample_tick.sv
// oversample_tick: divides clk_in into oversample ticks and tracks which
// oversample of the current serial bit each tick is; restart realigns both.
module oversample_tick #(
   parameter int CLK_PER_SAMP = 423,
   parameter int SAMP_PER_BIT = 16
) (
   input  logic                            clk_in,
   input  logic                            rst_in_n,
   input  logic                            i_restart,
   output logic                            o_tick,
   output logic [$clog2(SAMP_PER_BIT)-1:0] o_idx
);
   localparam int CW = $clog2(CLK_PER_SAMP + 1);
   localparam int IW = $clog2(SAMP_PER_BIT);

   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_idx;
   logic          w_tick;

   assign w_tick = r_cnt == CW'(CLK_PER_SAMP - 1);
   assign o_tick = w_tick;
   assign o_idx  = r_idx;

   always_ff @(posedge clk_in or negedge rst_in_n)
      if (!rst_in_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (i_restart) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) r_idx <= (r_idx == IW'(SAMP_PER_BIT - 1)) ? '0 : r_idx + 1'b1;
      end
endmodule

// File: rtl/board_link_rx.sv
// board_link_rx: oversampling UART-style packet receiver with idle holdoff.
// Define BOARD_LINK_RX_CHK_EN to enable sync-byte and XOR checksum validation.
module board_link_rx #(
   parameter int CLK_PER_SAMP  = 423,
   parameter int SAMP_PER_BIT  = 16,
   parameter int PKT_LEN       = board_link_pkg::PKT_LEN,
   parameter int WAITING_COUNT = 130_000
) (
   input  logic               clk_in,
   input  logic               rst_in_n,
   input  logic               rx,
   output logic [PKT_LEN-1:0] data_out,
   output logic               ready,
   output logic               frame_err,
   output logic               chk_err,
   output logic               busy
);
   import board_link_pkg::*;

   localparam int IW = $clog2(SAMP_PER_BIT);
   localparam int BW = $clog2(PKT_LEN + 1);
   localparam int HW = $clog2(WAITING_COUNT + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(PKT_LEN - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(WAITING_COUNT - 1);

   state_t             r_state, w_state_nxt;
   logic               r_rx_meta, r_rx_sync, r_rx_prev;
   logic               r_v7, r_v8;
   logic [PKT_LEN-1:0] r_shift, r_data;
   logic [BW-1:0]      r_bit_cnt;
   logic [HW-1:0]      r_hold_cnt;
   logic               r_ready, r_frame_err;
   logic               w_tick, w_fall, w_decide, w_bit, w_chk_ok;
   logic               w_ready_set, w_ferr_set;
   logic [IW-1:0]      w_idx;

   oversample_tick #(
      .CLK_PER_SAMP(CLK_PER_SAMP),
      .SAMP_PER_BIT(SAMP_PER_BIT)
   ) u_tick (
      .clk_in   (clk_in),
      .rst_in_n (rst_in_n),
      .i_restart(r_state == IDLE && w_fall),
      .o_tick   (w_tick),
      .o_idx    (w_idx)
   );

   // Synchronizer resets low so a line already low after reset never looks like a fresh edge
   always_ff @(posedge clk_in or negedge rst_in_n)
      if (!rst_in_n) {r_rx_meta, r_rx_sync, r_rx_prev} <= '0;
      else {r_rx_meta, r_rx_sync, r_rx_prev} <= {rx, r_rx_meta, r_rx_sync};

   assign w_fall   = r_rx_prev & ~r_rx_sync;
   assign w_decide = w_tick && w_idx == IW'(9);
   assign w_bit    = (r_v7 & r_v8) | (r_v7 & r_rx_sync) | (r_v8 & r_rx_sync);

   always_ff @(posedge clk_in or negedge rst_in_n)
      if (!rst_in_n) r_state <= IDLE;
      else r_state <= w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_ready_set = 1'b0;
      w_ferr_set  = 1'b0;
      case (r_state)
         IDLE:    if (w_fall) w_state_nxt = START;
         START:   if (w_decide) w_state_nxt = w_bit ? IDLE : DATA;
         DATA:    if (w_decide && r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
         STOP:
            if (w_decide) begin
               w_state_nxt = HOLDOFF;
               w_ready_set = w_bit & w_chk_ok;
               w_ferr_set  = ~w_bit;
            end
         HOLDOFF: if (r_rx_sync && r_hold_cnt == LAST_HOLD) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in_n)
      if (!rst_in_n) begin
         r_v7        <= 1'b0;
         r_v8        <= 1'b0;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_hold_cnt  <= '0;
         r_data      <= '0;
         r_ready     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_tick && w_idx == IW'(7)) r_v7 <= r_rx_sync;
         if (w_tick && w_idx == IW'(8)) r_v8 <= r_rx_sync;
         if (r_state == START) r_bit_cnt <= '0;
         else if (r_state == DATA && w_decide) begin
            r_shift   <= {w_bit, r_shift[PKT_LEN-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         r_hold_cnt  <= (r_state == HOLDOFF && r_rx_sync) ? r_hold_cnt + 1'b1 : '0;
         r_ready     <= w_ready_set;
         r_frame_err <= w_ferr_set;
         if (w_ready_set) r_data <= r_shift;
      end

`ifdef BOARD_LINK_RX_CHK_EN
   logic r_chk_err;
   logic w_cerr_set;

   assign w_chk_ok   = r_shift[CHK_MSB:CHK_LSB] == calc_chk(r_shift) &&
                       r_shift[SYNC_LSB +: 8] == SYNC_BYTE;
   assign w_cerr_set = r_state == STOP && w_decide && w_bit && !w_chk_ok;

   always_ff @(posedge clk_in or negedge rst_in_n)
      if (!rst_in_n) r_chk_err <= 1'b0;
      else r_chk_err <= w_cerr_set;

   assign chk_err = r_chk_err;
`else
   assign w_chk_ok = 1'b1;
   assign chk_err  = 1'b0;
`endif

   assign data_out  = r_data;
   assign ready     = r_ready;
   assign frame_err = r_frame_err;
   assign busy      = r_state != IDLE;
endmodule
